// File: rtl/risc16_run_ctrl_if.sv
// Host/core-facing signal bundle of the RiSC-16 run controller: program load
// stream, run commands, core fetch/enable/reset and status.
interface risc16_run_ctrl_if #(
    parameter int p_CNT_W = 32
);
    logic               load_valid;
    logic               load_ready;
    logic [15:0]        load_data;
    logic               load_last;
    logic               cmd_run;
    logic               cmd_step;
    logic               cmd_stop;
    logic [15:0]        core_pc;
    logic [15:0]        core_inst;
    logic               core_en;
    logic               core_rst;
    logic [2:0]         state;
    logic [p_CNT_W-1:0] exec_count;
    logic               load_ovf;

    modport master (
        output load_valid, load_data, load_last, cmd_run, cmd_step, cmd_stop, core_pc,
        input  load_ready, core_inst, core_en, core_rst, state, exec_count, load_ovf
    );

    modport slave (
        input  load_valid, load_data, load_last, cmd_run, cmd_step, cmd_stop, core_pc,
        output load_ready, core_inst, core_en, core_rst, state, exec_count, load_ovf
    );
endinterface

// File: rtl/risc16_run_ctrl.sv
// Run controller for the non-pipelined RiSC-16 core: owns instruction memory,
// accepts program loads and sequences the core through run/step/stop/halt/fault.
module risc16_run_ctrl #(
    parameter int p_INST_MEM_SIZE = 1024,
    parameter int p_CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    risc16_run_ctrl_if.slave  bus
);
    localparam int AW = (p_INST_MEM_SIZE > 1) ? $clog2(p_INST_MEM_SIZE) : 1;
    // load_addr must be able to hold p_INST_MEM_SIZE itself to flag overflow
    localparam int LW = $clog2(p_INST_MEM_SIZE + 1);
    localparam logic [16:0]        MEM_TOP = 17'(p_INST_MEM_SIZE);
    localparam logic [LW-1:0]      LA_TOP  = LW'(p_INST_MEM_SIZE);
    localparam logic [LW-1:0]      LA_ONE  = LW'(1);
    localparam logic [p_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [p_CNT_W-1:0] CNT_ONE = p_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CRST  = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LW-1:0]       load_addr;
    logic [LW-1:0]       wr_addr;
    logic                load_ovf_q;
    logic [p_CNT_W-1:0]  exec_count_q;
    logic [15:0]         mem [p_INST_MEM_SIZE];
    logic [15:0]         inst;
    logic                pc_in_range;
    logic                halt_inst;
    logic                beat;
    logic                executing;

    assign pc_in_range = {1'b0, bus.core_pc} < MEM_TOP;
    assign inst        = pc_in_range ? mem[bus.core_pc[AW-1:0]] : 16'h0000;
    assign halt_inst   = (inst[15:13] == 3'b111) && (inst[6:0] != 7'd0);
    assign executing   = (state_q == S_RUN) || (state_q == S_STEP);

    assign bus.load_ready = !rst && ((state_q == S_IDLE) || (state_q == S_LOAD) ||
                                     (state_q == S_HALT) || (state_q == S_FAULT));
    assign beat           = bus.load_valid && bus.load_ready;
    assign wr_addr        = (state_q == S_LOAD) ? load_addr : '0;

    assign bus.core_inst  = inst;
    assign bus.core_en    = !rst && executing && !halt_inst && pc_in_range;
    assign bus.core_rst   = rst || (state_q == S_CRST);
    assign bus.state      = state_q;
    assign bus.exec_count = exec_count_q;
    assign bus.load_ovf   = load_ovf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beat)
                    state_d = bus.load_last ? S_CRST : S_LOAD;
                else if (bus.cmd_stop)
                    state_d = S_IDLE;
                else if (bus.cmd_step)
                    state_d = S_STEP;
                else if (bus.cmd_run)
                    state_d = S_RUN;
            end
            S_LOAD: begin
                if (beat && bus.load_last)
                    state_d = S_CRST;
            end
            S_CRST: state_d = S_IDLE;
            // Halt and fault outrank stop: core_en is already low in that cycle
            S_RUN: begin
                if (halt_inst)
                    state_d = S_HALT;
                else if (!pc_in_range)
                    state_d = S_FAULT;
                else if (bus.cmd_stop)
                    state_d = S_IDLE;
            end
            S_STEP: begin
                if (halt_inst)
                    state_d = S_HALT;
                else if (!pc_in_range)
                    state_d = S_FAULT;
                else
                    state_d = S_IDLE;
            end
            S_HALT, S_FAULT: begin
                if (beat)
                    state_d = bus.load_last ? S_CRST : S_LOAD;
                else if (bus.cmd_stop)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_addr    <= '0;
            load_ovf_q   <= 1'b0;
            exec_count_q <= '0;
        end else begin
            state_q <= state_d;
            // A beat arriving outside LOAD starts a fresh program at address 0
            if (beat) begin
                if (state_q != S_LOAD) begin
                    load_addr  <= LA_ONE;
                    load_ovf_q <= 1'b0;
                end else if (load_addr < LA_TOP) begin
                    load_addr  <= load_addr + LA_ONE;
                end else begin
                    load_ovf_q <= 1'b1;
                end
            end
            if (state_q == S_CRST)
                exec_count_q <= '0;
            else if (bus.core_en && (exec_count_q != CNT_MAX))
                exec_count_q <= exec_count_q + CNT_ONE;
        end
    end

    // Program storage is deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (beat && (wr_addr < LA_TOP))
            mem[wr_addr[AW-1:0]] <= bus.load_data;
    end
endmodule

// File: tb/tb_risc16_run_ctrl.sv
// Bench for risc16_run_ctrl: a stand-in RiSC-16 core plus an ISA-level reference
// that predicts retirement counts, final state, PC and registers.
module tb_risc16_run_ctrl;
    localparam int SIZE = 16;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc16_run_ctrl_if #(.p_CNT_W(CW)) bus ();
    risc16_run_ctrl #(.p_INST_MEM_SIZE(SIZE), .p_CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] npc;
        logic        wr;
        logic [2:0]  wa;
        logic [15:0] wd;
    } isa_t;

    // RiSC-16 instruction semantics (lw/sw treated as no-ops; never generated)
    function automatic isa_t isa(input logic [15:0] i, input logic [15:0] pc,
                                 input logic [15:0] ra, input logic [15:0] rb,
                                 input logic [15:0] rc);
        isa_t r;
        logic [15:0] simm;
        simm = {{9{i[6]}}, i[6:0]};
        r.npc = pc + 16'd1;
        r.wr  = 1'b0;
        r.wa  = i[12:10];
        r.wd  = 16'h0;
        case (i[15:13])
            3'b000: begin r.wr = 1'b1; r.wd = rb + rc; end
            3'b001: begin r.wr = 1'b1; r.wd = rb + simm; end
            3'b010: begin r.wr = 1'b1; r.wd = ~(rb & rc); end
            3'b011: begin r.wr = 1'b1; r.wd = {i[9:0], 6'b0}; end
            3'b110: if (ra == rb) r.npc = pc + 16'd1 + simm;
            3'b111: begin r.wr = 1'b1; r.wd = pc + 16'd1; r.npc = rb; end
            default: ;
        endcase
        if (r.wa == 3'd0) r.wr = 1'b0;
        return r;
    endfunction

    // Stand-in core driven only by the controller's outputs
    logic [15:0] cpc;
    logic [15:0] creg [8];
    isa_t        core_nx;
    assign bus.core_pc = cpc;
    assign core_nx = isa(bus.core_inst, cpc, creg[bus.core_inst[12:10]],
                         creg[bus.core_inst[9:7]], creg[bus.core_inst[2:0]]);
    always @(posedge clk) begin
        if (bus.core_rst) begin
            cpc <= 16'h0;
            for (int i = 0; i < 8; i++) creg[i] <= 16'h0;
        end else if (bus.core_en) begin
            cpc <= core_nx.npc;
            if (core_nx.wr) creg[core_nx.wa] <= core_nx.wd;
        end
    end

    // Reference model state
    logic [15:0] ref_mem [SIZE];
    logic [15:0] rpc;
    logic [15:0] rreg [8];
    int          rcnt;
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_reset();
        rpc  = 16'h0;
        rcnt = 0;
        for (int i = 0; i < 8; i++) rreg[i] = 16'h0;
    endtask

    function automatic int sat(input int c);
        return (c > CMAX) ? CMAX : c;
    endfunction

    // Retire up to max instructions; st = 3 (still running), 5 (halt) or 6 (fault)
    task automatic ref_exec(input int max, output int n, output int st);
        isa_t r;
        logic [15:0] i;
        bit done;
        n = 0; st = 3; done = 0;
        while (!done && n < max) begin
            if (int'(rpc) >= SIZE) begin
                st = 6; done = 1;
            end else begin
                i = ref_mem[int'(rpc)];
                if (i[15:13] == 3'b111 && i[6:0] != 7'd0) begin
                    st = 5; done = 1;
                end else begin
                    r = isa(i, rpc, rreg[i[12:10]], rreg[i[9:7]], rreg[i[2:0]]);
                    rpc = r.npc;
                    if (r.wr) rreg[r.wa] = r.wd;
                    n++;
                    rcnt++;
                end
            end
        end
    endtask

    task automatic chk_core(input string tag);
        chk({tag, "_pc"}, cpc, rpc);
        for (int i = 1; i < 8; i++) chk({tag, "_reg"}, creg[i], rreg[i]);
        chk({tag, "_cnt"}, bus.exec_count, sat(rcnt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", bus.load_ready, 0);
        chk("rst_core_rst", bus.core_rst, 1);
        chk("rst_core_en", bus.core_en, 0);
        tick();
        chk("rst_state", bus.state, 0);
        chk("rst_cnt", bus.exec_count, 0);
        chk("rst_ovf", bus.load_ovf, 0);
        chk("rst_ready_hi", bus.load_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after", bus.load_ready, 1);
        ref_reset();
    endtask

    task automatic load_prog(input logic [15:0] w[$], input bit fin);
        int n;
        n = w.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            chk("ld_ready", bus.load_ready, 1);
            bus.load_valid = 1'b1;
            bus.load_data  = w[i];
            bus.load_last  = fin && (i == n - 1);
            tick();
            bus.load_valid = 1'b0;
            bus.load_last  = 1'b0;
            if (i < SIZE) ref_mem[i] = w[i];
            if (!(fin && i == n - 1)) begin
                chk("ld_state", bus.state, 1);
                chk("ld_ovf", bus.load_ovf, (i >= SIZE) ? 1 : 0);
            end
        end
        if (fin) begin
            chk("crst_state", bus.state, 2);
            chk("crst_core_rst", bus.core_rst, 1);
            chk("crst_ready", bus.load_ready, 0);
            chk("crst_ovf", bus.load_ovf, (n > SIZE) ? 1 : 0);
            tick();
            chk("post_ld_state", bus.state, 0);
            chk("post_ld_core_rst", bus.core_rst, 0);
            chk("post_ld_cnt", bus.exec_count, 0);
            ref_reset();
        end
    endtask

    task automatic run_prog(input int limit);
        int n, st, cyc;
        bus.cmd_run = 1'b1;
        tick();
        bus.cmd_run = 1'b0;
        chk("run_state", bus.state, 3);
        ref_exec(limit, n, st);
        cyc = 0;
        while (bus.state == 3'd3 && cyc < limit) begin
            tick();
            cyc++;
        end
        chk("run_latency", cyc, n + 1);
        chk("run_end_state", bus.state, st);
        chk("run_core_en", bus.core_en, 0);
        if (st == 6) chk("fault_inst", bus.core_inst, 0);
        chk_core("run");
    endtask

    task automatic run_for(input int k);
        int n, st;
        bus.cmd_run = 1'b1;
        tick();
        bus.cmd_run = 1'b0;
        repeat (k - 1) tick();
        bus.cmd_stop = 1'b1;
        tick();
        bus.cmd_stop = 1'b0;
        ref_exec(k, n, st);
        chk("stop_state", bus.state, 0);
        chk("stop_core_en", bus.core_en, 0);
        chk_core("stop");
    endtask

    task automatic step_once();
        int n, st;
        bus.cmd_step = 1'b1;
        tick();
        bus.cmd_step = 1'b0;
        chk("step_state", bus.state, 4);
        ref_exec(1, n, st);
        tick();
        chk("step_next", bus.state, (st == 3) ? 0 : st);
        chk_core("step");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] prog[$];
        logic [15:0] w;
        int len;
        rst = 1'b1;
        bus.load_valid = 1'b0; bus.load_data = 16'h0; bus.load_last = 1'b0;
        bus.cmd_run = 1'b0; bus.cmd_step = 1'b0; bus.cmd_stop = 1'b0;
        tick();
        do_reset();

        // Overflowing load: 18 words into 16, then jalr to PC 20 faults
        prog = '{16'h2814, 16'hED00};
        for (int i = 2; i < 18; i++) prog.push_back(16'h2481);
        load_prog(prog, 1);
        chk("ovf_set", bus.load_ovf, 1);
        run_prog(40);
        chk("fault_state", bus.state, 6);
        chk("fault_pc", cpc, 16'd20);
        do_reset();

        // Directed: two addi then halt
        prog = '{16'h2481, 16'h2481, 16'hE001};
        load_prog(prog, 1);
        run_prog(20);
        chk("halt_r1", creg[1], 16'd2);
        chk("halt_pc", cpc, 16'd2);
        chk("halt_cnt", bus.exec_count, 2);

        // Commands in HALT
        bus.cmd_run = 1'b1; tick(); bus.cmd_run = 1'b0;
        chk("halt_run_ign", bus.state, 5);
        bus.cmd_step = 1'b1; tick(); bus.cmd_step = 1'b0;
        chk("halt_step_ign", bus.state, 5);
        bus.cmd_stop = 1'b1; tick(); bus.cmd_stop = 1'b0;
        chk("halt_stop", bus.state, 0);
        run_prog(20);
        chk("rehalt_cnt", bus.exec_count, 2);

        // Single-stepping the same program
        load_prog(prog, 1);
        repeat (3) begin
            step_once();
            repeat (2) tick();
        end
        chk("step_halt", bus.state, 5);
        chk("step_cnt", bus.exec_count, 2);

        // Tight loop, stop after 10, then saturate the counter
        prog = '{16'hC07F};
        load_prog(prog, 1);
        run_for(10);
        chk("loop_cnt", bus.exec_count, 10);
        run_for(8);
        chk("loop_sat", bus.exec_count, CMAX);

        // Reset mid-run
        bus.cmd_run = 1'b1; tick(); bus.cmd_run = 1'b0;
        repeat (3) tick();
        do_reset();

        // Reset mid-load; written words remain
        prog = '{16'h2481, 16'h2881, 16'h1234};
        load_prog(prog, 0);
        do_reset();
        chk("mem_kept", bus.core_inst, ref_mem[0]);
        run_prog(60);

        // Randomized programs ending in halt or an out-of-range jump
        for (int it = 0; it < 10; it++) begin
            prog = {};
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) begin
                w = {3'($urandom_range(0, 3)), 13'($urandom)};
                prog.push_back(w);
            end
            if ($urandom_range(0, 3) == 0) begin
                prog.push_back({3'b001, 3'd7, 3'd0, 7'($urandom_range(16, 63))});
                prog.push_back({3'b111, 3'd6, 3'd7, 7'd0});
            end else begin
                prog.push_back({3'b111, 6'($urandom), 7'($urandom_range(1, 127))});
            end
            load_prog(prog, 1);
            run_prog(60);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/risc16_run_ctrl.md
# risc16_run_ctrl

Run controller for the non-pipelined RiSC-16 core. Owns the instruction memory, loads programs into it over a valid/ready stream, and sequences the core through run, single-step, stop, halt and fault states. It does this by driving the core's instruction input, enable and synchronous reset. It sits between the bench or debug host and `core`. The core's PC output indexes this block's memory.

## Interface

Parameters:
- `p_INST_MEM_SIZE`, 1024: instruction words held; valid PCs are 0 .. p_INST_MEM_SIZE-1.
- `p_CNT_W`, 32: width of the executed-instruction counter.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  program word offered.
- `load_ready`  out  1  program word can be accepted.
- `load_data`  in  16  program word.
- `load_last`  in  1  marks the final word of a program.
- `cmd_run`, `cmd_step`, `cmd_stop`  in  1 each  single-cycle command pulses.
- `core_pc`  in  16  PC from the core.
- `core_inst`  out  16  instruction presented to the core.
- `core_en`  out  1  core executes `core_inst` at this rising edge.
- `core_rst`  out  1  synchronous reset to the core.
- `state`  out  3  encoded FSM state.
- `exec_count`  out  p_CNT_W  number of instructions executed.
- `load_ovf`  out  1  sticky: a load beat exceeded the memory size.

## Operation

- States and encodings: IDLE=0, LOAD=1, CRST=2, RUN=3, STEP=4, HALT=5, FAULT=6.
- Memory:
  - Write port: synchronous, driven by the load stream.
  - Read port: asynchronous, `core_inst = mem[core_pc]` when `core_pc < p_INST_MEM_SIZE`, else 16'h0000.
  - Contents are not cleared by `rst`.
- Load handshake:
  - A beat transfers on an edge where `load_valid && load_ready`.
  - `load_ready` = 1 in IDLE, LOAD, HALT and FAULT; it is 0 in CRST, RUN and STEP, and 0 while `rst` is high.
- Load sequencing:
  - A beat accepted outside LOAD writes address 0, sets `load_addr`=1, clears `load_ovf` and enters LOAD. If that beat also has `load_last`, the block enters CRST instead.
  - In LOAD, each beat writes `mem[load_addr]` and increments `load_addr`.
  - A beat addressed at or beyond p_INST_MEM_SIZE is discarded and sets `load_ovf`.
  - A beat with `load_last` moves LOAD to CRST.
- CRST: `core_rst`=1 for exactly one cycle, `exec_count` cleared, then IDLE.
- Commands:
  - Priority is stop > step > run. Commands are ignored in LOAD and CRST.
  - From IDLE, `cmd_run` enters RUN and `cmd_step` enters STEP.
  - In RUN or STEP, `cmd_stop` enters IDLE.
  - In HALT or FAULT, `cmd_stop` enters IDLE; run and step are ignored.
- Halt instruction: `core_inst[15:13]==3'b111 && core_inst[6:0]!=0`.
- `core_en` is combinational and equals `(state==RUN || state==STEP) && !halt_inst && pc_in_range`.
- RUN:
  - If halt_inst: `core_en`=0 and next state is HALT. The PC stays on the halt word.
  - If the PC is out of range: `core_en`=0 and next state is FAULT.
  - Otherwise one instruction retires per cycle.
- STEP: exactly one cycle in this state, then IDLE. The same halt and fault checks apply (next state HALT or FAULT).
- `cmd_stop` in RUN does not suppress the instruction executing in that same cycle. `core_en` drops from the next cycle.
- `exec_count` increments on every edge with `core_en`=1 and saturates at all-ones.
- `core_rst = rst || state==CRST`.

## Timing

- Reset values:
  - state IDLE, `load_addr` 0, `exec_count` 0, `load_ovf` 0.
  - `core_en` 0, `core_rst` 1 (during `rst`), `load_ready` 0 during `rst`.
- Command latency: a command sampled at edge N sets the new state at N. `core_en` follows in the cycle after edge N.
- Run start: the first instruction executes at edge N+1 after `cmd_run` is sampled at N.
- Load to run: a program becomes runnable 2 edges after the `load_last` beat (the CRST cycle, then IDLE).
- Reset mid-operation: `rst` overrides everything. The core is reset, state returns to IDLE and any partial load is abandoned; memory words already written remain.
- Simultaneous `cmd_stop` and halt_inst in RUN: the result is HALT. The halt check wins because `core_en` is already 0 in that cycle.

## Test plan

- Load [0x2481 (addi r1,r1,1), 0x2481, 0xE001 (halt)] with `load_last` on the third word, then `cmd_run` -> r1=2, state HALT, `core_pc`=2, `exec_count`=2.
- Same program, `cmd_step` three times, each followed by idle cycles -> after each step r1 is 1, then 2, then unchanged; states STEP→IDLE, STEP→IDLE, then HALT; `exec_count`=2.
- Load a loop `beq r0,r0,-1` (0xC07F), run 10 cycles, pulse `cmd_stop` -> state IDLE next edge, `exec_count`=10 (the stop-cycle instruction is counted), PC unchanged.
- With p_INST_MEM_SIZE=4, load 6 words -> `load_ovf`=1, words 4 and 5 dropped, CRST pulses once. Jump to PC 8 while running -> `core_en`=0, state FAULT, `core_inst`=0.
- Assert `rst` during RUN and during LOAD -> state IDLE, `core_rst`=1, `exec_count`=0, `load_ready`=0 while high. Earlier-loaded words are still readable afterwards.
- `cmd_run` while in HALT -> ignored; `cmd_stop` then `cmd_run` -> halts again immediately with `exec_count` unchanged.
